// File: rtl/prog_loader.sv
// prog_loader: receives a length-prefixed little-endian byte stream and writes it word by word into instruction memory.
`ifndef ROM_ADDRESS_BITWIDTH
`define ROM_ADDRESS_BITWIDTH 12
`endif
`ifndef ROM_SIZE
`define ROM_SIZE 4096
`endif
module prog_loader #(
  parameter int ADDR_W    = `ROM_ADDRESS_BITWIDTH,
  parameter int MAX_WORDS = `ROM_SIZE / 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              start,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam int IW = $clog2(MAX_WORDS + 1);
  localparam logic [1:0] S_LEN = 2'd0, S_DATA = 2'd1, S_DONE = 2'd2, S_ERR = 2'd3;
  logic [1:0]        state_q, state_d, cnt_q, cnt_d;
  logic [23:0]       buf_q, buf_d;
  logic [31:0]       len_q, len_d, wdata_q, wdata_d, word;
  logic [IW-1:0]     idx_q, idx_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              we_q, we_d, acc, last_byte, last_word;
  assign rx_ready  = (state_q == S_LEN) || (state_q == S_DATA);
  assign acc       = rx_valid && rx_ready;
  assign last_byte = acc && (cnt_q == 2'd3);
  // the three earlier bytes sit in buf_q, so the arriving byte completes the word
  assign word      = {rx_data, buf_q};
  assign last_word = (32'(idx_q) + 32'd1) == len_q;
  assign busy      = rx_ready;
  assign done      = state_q == S_DONE;
  assign error     = state_q == S_ERR;
  assign we        = we_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = acc ? cnt_q + 2'd1 : cnt_q;
    buf_d   = acc ? word[31:8] : buf_q;
    len_d   = len_q;
    idx_d   = idx_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (last_byte && state_q == S_LEN) begin
      len_d   = word;
      idx_d   = '0;
      state_d = (word == 32'd0) ? S_DONE : (word > 32'(MAX_WORDS)) ? S_ERR : S_DATA;
    end
    if (last_byte && state_q == S_DATA) begin
      we_d    = 1'b1;
      waddr_d = ADDR_W'({idx_q, 2'b00});
      wdata_d = word;
      idx_d   = idx_q + IW'(1);
      state_d = last_word ? S_DONE : S_DATA;
    end
    if (start && !rx_ready) begin
      state_d = S_LEN;
      cnt_d   = '0;
      idx_d   = '0;
      len_d   = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_LEN;
      cnt_q   <= '0;
      buf_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed-vector bench for prog_loader with a small MAX_WORDS so the length limits are reachable.
module tb_prog_loader;
  localparam int ADDR_W = 8;
  localparam int MAX_WORDS = 4;
  logic clk = 1'b0, reset_n = 1'b0, rx_valid = 1'b0, start = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_ready, we, busy, done, error;
  logic [ADDR_W-1:0] waddr;
  logic [31:0] wdata;
  int n_run = 0, n_fail = 0;
  typedef struct packed {logic [ADDR_W-1:0] a; logic [31:0] d; logic dn;} wr_t;
  wr_t wq[$];
  prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .start(start), .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done), .error(error)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (we) wq.push_back('{waddr, wdata, done});
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic wr_t ent(input int k);
    return (k < wq.size()) ? wq[k] : '1;
  endfunction
  task automatic put(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask
  task automatic put_word(input logic [31:0] w, input int gap);
    for (int j = 0; j < 4; j++) put(w[8*j +: 8], gap);
  endtask
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  task automatic settle();
    @(negedge clk); #1;
  endtask
  task automatic two_word(input string tag, input int gap);
    wq.delete();
    put_word(32'h0000_0002, gap);
    put_word(32'h0000_0013, gap);
    put_word(32'h0010_0093, gap);
    settle();
    check({tag, "_nwe"}, wq.size(), 2);
    check({tag, "_a0"}, ent(0).a, 0);
    check({tag, "_d0"}, ent(0).d, 32'h0000_0013);
    check({tag, "_dn0"}, ent(0).dn, 0);
    check({tag, "_a1"}, ent(1).a, 4);
    check({tag, "_d1"}, ent(1).d, 32'h0010_0093);
    check({tag, "_dn1"}, ent(1).dn, 1);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    settle();
    check({tag, "_rdy"}, rx_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 1);
    rx_valid = 1'b0;
    check({tag, "_extra"}, wq.size(), 2);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    settle();
    check("rst_we", we, 0);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_busy", busy, 1);
    check("rst_rdy", rx_ready, 1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    two_word("burst", 0);
    pulse_start();
    check("restart_busy", busy, 1);
    check("restart_done", done, 0);
    two_word("stall", 3);
    pulse_start();
    wq.delete();
    put_word(32'h0, 0);
    settle();
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_nwe", wq.size(), 0);
    pulse_start();
    put_word(32'(MAX_WORDS + 1), 0);
    settle();
    check("over_err", error, 1);
    check("over_rdy", rx_ready, 0);
    check("over_done", done, 0);
    check("over_nwe", wq.size(), 0);
    pulse_start();
    check("over_clr_err", error, 0);
    check("over_clr_busy", busy, 1);
    put_word(32'h1, 0);
    put_word(32'hDEAD_BEEF, 0);
    settle();
    check("over_then_nwe", wq.size(), 1);
    check("over_then_d", ent(0).d, 32'hDEAD_BEEF);
    check("over_then_done", done, 1);
    pulse_start();
    wq.delete();
    put_word(32'(MAX_WORDS), 0);
    put_word(32'h0403_0201, 0);
    start = 1'b1;
    put_word(32'h0807_0605, 0);
    start = 1'b0;
    check("max_ign_busy", busy, 1);
    put_word(32'h0C0B_0A09, 0);
    put_word(32'h100F_0E0D, 0);
    settle();
    check("max_nwe", wq.size(), MAX_WORDS);
    check("max_a1", ent(1).a, 4);
    check("max_d1", ent(1).d, 32'h0807_0605);
    check("max_alast", ent(MAX_WORDS - 1).a, (MAX_WORDS - 1) * 4);
    check("max_dlast", ent(MAX_WORDS - 1).d, 32'h100F_0E0D);
    check("max_done", done, 1);
    check("max_err", error, 0);
    pulse_start();
    put_word(32'h3, 0);
    put_word(32'hAAAA_AAAA, 0);
    settle();
    wq.delete();
    put(8'h55, 0);
    put(8'h66, 0);
    reset_n = 1'b0;
    rx_valid = 1'b1;
    rx_data = 8'h77;
    start = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    rx_valid = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    settle();
    check("rstmid_nwe", wq.size(), 0);
    check("rstmid_busy", busy, 1);
    check("rstmid_we", we, 0);
    put_word(32'h1, 0);
    put_word(32'h1234_5678, 0);
    settle();
    check("fresh_nwe", wq.size(), 1);
    check("fresh_a", ent(0).a, 0);
    check("fresh_d", ent(0).d, 32'h1234_5678);
    check("fresh_done", done, 1);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default `ROM_ADDRESS_BITWIDTH, SHALL set the byte-address width of the instruction-memory write port.
REQ-002 Parameter MAX_WORDS, default `ROM_SIZE / 4, SHALL set the largest accepted program length in 32-bit words.
REQ-003 Port clk, input, 1, SHALL be the clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1, SHALL be the reset: synchronous, active-low.
REQ-005 Port rx_data, input, 8, SHALL carry the incoming program byte.
REQ-006 Port rx_valid, input, 1, SHALL indicate that rx_data holds a byte.
REQ-007 Port rx_ready, output, 1, SHALL indicate that the loader accepts a byte this cycle; a byte transfers when rx_valid && rx_ready at the clock edge.
REQ-008 Port start, input, 1, SHALL be a one-cycle request to begin a new load.
REQ-009 Port we, output, 1, SHALL be the instruction-memory write strobe, one cycle per word.
REQ-010 Port waddr, output, ADDR_W, SHALL be the byte address of the word written; bits [1:0] always 0.
REQ-011 Port wdata, output, 32, SHALL be the word written.
REQ-012 Port busy, output, 1, SHALL be high while a load is in progress; the CPU is held in reset from it.
REQ-013 Port done, output, 1, SHALL be high after a successful load until the next start or reset.
REQ-014 Port error, output, 1, SHALL be high after a rejected length until the next start or reset.

Function
REQ-015 States SHALL be LEN, DATA, DONE and ERR; busy = (LEN or DATA); done = DONE; error = ERR.
REQ-016 rx_ready SHALL be a function of state only: 1 in LEN and DATA, 0 in DONE and ERR.
REQ-017 Stream format SHALL be a 4-byte little-endian length N, then N words of 4 bytes each, little-endian: first byte -> bits [7:0], fourth -> bits [31:24].
REQ-018 A 2-bit byte counter SHALL count accepted bytes in LEN and DATA, wrap from 3 to 0, and clear on every state change.
REQ-019 On the edge accepting the 4th length byte, next state SHALL be: DONE if N==0; ERR if N>MAX_WORDS; otherwise DATA with word index cleared.
REQ-020 N==MAX_WORDS SHALL be accepted; N==MAX_WORDS+1 SHALL go to ERR.
REQ-021 On the edge accepting the 4th byte of word i, we, waddr=i*4 and wdata SHALL be registered; we is high for exactly the following cycle, and waddr/wdata hold until the next write.
REQ-022 If word i is word N-1, the same edge SHALL move the state to DONE, so done rises in the cycle in which the last we is high.
REQ-023 Cycles with rx_valid low SHALL not advance any counter; stalls of any length between bytes SHALL be tolerated.
REQ-024 start SHALL be ignored in LEN and DATA; in DONE or ERR, start SHALL move the state to LEN on the next edge, clearing done/error and all counters.
REQ-025 In DONE and ERR, bytes presented SHALL not be consumed, because rx_ready is 0.
REQ-026 The word index SHALL be wide enough to count to MAX_WORDS without wrap.

Reset
REQ-027 With reset_n low at an edge, the state SHALL become LEN with byte counter, word index and length cleared; outputs we=0, waddr=0, wdata=0, done=0, error=0, busy=1, rx_ready=1.
REQ-028 Reset asserted mid-DATA SHALL abandon the load with no further we; partial words SHALL be discarded.
REQ-029 Reset SHALL take priority over start and over byte acceptance in the same cycle.

Verification
REQ-030 Stream 02 00 00 00, 13 00 00 00, 93 00 10 00 with rx_valid held high -> we pulses at waddr 0 with wdata 0x00000013, then at waddr 4 with wdata 0x00100093; done rises in the cycle of the second we; rx_ready=0 afterwards.
REQ-031 Same stream with rx_valid low for 3 cycles between every byte -> identical we/waddr/wdata sequence; no extra we.
REQ-032 Length 00 00 00 00 -> DONE one edge after the 4th byte; no we; busy=0.
REQ-033 Length MAX_WORDS+1 -> error=1, rx_ready=0, no we; then a start pulse -> error=0, busy=1, and a valid 1-word load succeeds.
REQ-034 Length MAX_WORDS with an incrementing pattern -> last we at waddr (MAX_WORDS-1)*4, done=1, no error.
REQ-035 reset_n low after 2 bytes of word 1 in a 3-word load -> LEN, no we; a fresh 1-word stream writes waddr 0 correctly.
